// File: rtl/tx_framer_pkg.sv
// tx_framer_pkg: shared state type, defaults and checksum step for tx_framer (TX_FRAMER_CRC8_EN selects CRC-8)
package tx_framer_pkg;
  typedef enum logic [2:0] {IDLE, GATHER, POP_WAIT, SEND_SYNC, SEND_LEN, SEND_PAY, SEND_CHK} state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  // One checksum step: XOR by default, CRC-8 (MSB-first, init 0, no reflection) when the macro is set
  function automatic logic [7:0] chk_next(input logic [7:0] chk, input logic [7:0] din);
`ifdef TX_FRAMER_CRC8_EN
    logic [7:0] c;
    c = chk ^ din;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    return c;
`else
    return chk ^ din;
`endif
  endfunction
endpackage

// File: rtl/tx_framer_chk.sv
// tx_framer_chk: checksum accumulator with clear and bytewise update
module tx_framer_chk import tx_framer_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       upd,
  input  logic [7:0] din,
  output logic [7:0] value
);
  logic [7:0] chk_q, chk_d;
  // Next accumulator value: clear wins over update
  always_comb chk_d = clr ? 8'h00 : upd ? chk_next(chk_q, din) : chk_q;
  // Accumulator register
  always_ff @(posedge clk or posedge rst)
    if (rst) chk_q <= 8'h00;
    else chk_q <= chk_d;
  assign value = chk_q;
endmodule

// File: rtl/tx_framer.sv
// tx_framer: packs buffered bytes into SYNC,LEN,payload,CHK frames for uart_tx (TX_FRAMER_CRC8_EN selects CRC-8 CHK)
module tx_framer import tx_framer_pkg::*; #(
  parameter int         MAX_PAYLOAD    = 32,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  buf_data,
  input  logic        buf_valid,
  output logic        buf_read_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frame_count
);
  localparam int AW = MAX_PAYLOAD > 1 ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, ptr_q, ptr_d, tx_data_q, tx_data_d, chk_val, chk_din;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic wait_q, wait_d, rd_q, rd_d, tx_valid_q, tx_valid_d, load, xfer, chk_clr, chk_upd;
  logic [7:0] mem_q [MAX_PAYLOAD];
  logic [7:0] mem_d [MAX_PAYLOAD];
  // A send state with tx_valid low is the one-cycle load slot where the next byte is presented
  assign load = (state_q inside {SEND_SYNC, SEND_LEN, SEND_PAY, SEND_CHK}) && !tx_valid_q;
  assign xfer = tx_valid_q && tx_ready;
  assign chk_clr = load && state_q == SEND_SYNC;
  assign chk_upd = load && (state_q == SEND_LEN || state_q == SEND_PAY);
  assign chk_din = state_q == SEND_LEN ? cnt_q : mem_q[ptr_q[AW-1:0]];
  tx_framer_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .clr  (chk_clr),
    .upd  (chk_upd),
    .din  (chk_din),
    .value(chk_val)
  );
  // Framing FSM next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    tmo_d = tmo_q;
    wait_d = 1'b0;
    rd_d = 1'b0;
    tx_data_d = tx_data_q;
    tx_valid_d = tx_valid_q;
    frame_count_d = frame_count_q;
    mem_d = mem_q;
    if (load) begin
      tx_valid_d = 1'b1;
      tx_data_d = state_q == SEND_SYNC ? SYNC_BYTE : state_q == SEND_LEN ? cnt_q :
                  state_q == SEND_PAY ? mem_q[ptr_q[AW-1:0]] : chk_val;
    end
    case (state_q)
      IDLE: if (enable && buf_valid) state_d = GATHER;
      GATHER:
        if (cnt_q == MAX_LEN) state_d = SEND_SYNC;
        else if (buf_valid) begin
          mem_d[cnt_q[AW-1:0]] = buf_data;
          cnt_d = cnt_q + 8'd1;
          tmo_d = '0;
          rd_d = 1'b1;
          state_d = POP_WAIT;
        end else if (cnt_q != 8'd0) begin
          tmo_d = tmo_q == TMO_LAST ? '0 : tmo_q + 1'b1;
          state_d = tmo_q == TMO_LAST ? SEND_SYNC : GATHER;
        end
      POP_WAIT: begin
        wait_d = !wait_q;
        state_d = wait_q ? GATHER : POP_WAIT;
      end
      default:
        if (xfer) begin
          tx_valid_d = 1'b0;
          state_d = state_q == SEND_SYNC ? SEND_LEN : state_q == SEND_LEN ? SEND_PAY :
                    state_q == SEND_PAY ? (ptr_q == cnt_q - 8'd1 ? SEND_CHK : SEND_PAY) : IDLE;
          ptr_d = state_q == SEND_PAY ? ptr_q + 8'd1 : 8'd0;
          cnt_d = state_q == SEND_CHK ? 8'd0 : cnt_q;
          frame_count_d = state_q == SEND_CHK ? frame_count_q + 16'd1 : frame_count_q;
        end
    endcase
  end
  // Control and output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      ptr_q <= 8'd0;
      tmo_q <= '0;
      wait_q <= 1'b0;
      rd_q <= 1'b0;
      tx_data_q <= 8'd0;
      tx_valid_q <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      tmo_q <= tmo_d;
      wait_q <= wait_d;
      rd_q <= rd_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      frame_count_q <= frame_count_d;
    end
  // Payload store needs no reset: slots are always written before they are read
  always_ff @(posedge clk) mem_q <= mem_d;
  assign buf_read_en = rd_q;
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy = state_q != IDLE;
  assign frame_count = frame_count_q;
endmodule
